sif_addsub_pipe: RTL and testbench

//   Parametrised multi-lane signed integer adder/subtractor with full valid/ready

---
 rtl/sif_addsub_pipe_if.sv | 29 ++
 rtl/sif_addsub_pipe.sv | 101 ++++++++++
 tb/tb_sif_addsub_pipe.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sif_addsub_pipe_if.sv
// Operand/result bus for sif_addsub_pipe: two joined operand streams in, one result stream out.
// A beat moves on X_vld & X_rdy. A_rdy/B_rdy depend only on the partner valid and pipe space.
interface sif_addsub_pipe_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
);
    logic [LANES-1:0]       is_sub;
    logic                   A_vld;
    logic [LANES*WIDTH-1:0] A_dat;
    logic                   A_rdy;
    logic                   B_vld;
    logic [LANES*WIDTH-1:0] B_dat;
    logic                   B_rdy;
    logic                   S_vld;
    logic [LANES*WIDTH-1:0] S_dat;
    logic [LANES-1:0]       S_ovf;
    logic                   S_rdy;
    logic                   busy;

    modport master (
        output is_sub, A_vld, A_dat, B_vld, B_dat, S_rdy,
        input  A_rdy, B_rdy, S_vld, S_dat, S_ovf, busy
    );

    modport slave (
        input  is_sub, A_vld, A_dat, B_vld, B_dat, S_rdy,
        output A_rdy, B_rdy, S_vld, S_dat, S_ovf, busy
    );
endinterface

// File: rtl/sif_addsub_pipe.sv
// Multi-lane signed add/sub with joined operand handshake and an elastic LATENCY-deep pipeline.
// Define SIF_ADDSUB_SAT_EN to saturate overflowing lanes instead of wrapping.
module sif_addsub_pipe #(
    parameter int WIDTH   = 16,
    parameter int LANES   = 4,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sif_addsub_pipe_if.slave   bus
);

    logic [LATENCY-1:0]     vld_q;
    logic [LANES*WIDTH-1:0] dat_q [LATENCY];
    logic [LANES-1:0]       ovf_q [LATENCY];

    logic [LATENCY-1:0]     rdy;
    logic                   in_rdy;
    logic                   fire;
    logic [LANES*WIDTH-1:0] res_d;
    logic [LANES-1:0]       ovf_d;

    // Returns {ovf, result}; operands are sign-extended one bit so ovf is the top-two-bit disagreement.
    function automatic logic [WIDTH:0] lane_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sub);
        logic [WIDTH-1:0] bop;
        logic [WIDTH:0]   sum;
        logic             ovf;
        logic [WIDTH-1:0] res;
        bop = sub ? ~b : b;
        sum = {a[WIDTH-1], a} + {bop[WIDTH-1], bop} + {{WIDTH{1'b0}}, sub};
        ovf = sum[WIDTH] ^ sum[WIDTH-1];
        res = sum[WIDTH-1:0];
`ifdef SIF_ADDSUB_SAT_EN
        if (ovf) begin
            res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        return {ovf, res};
    endfunction

    // A stage can take a new entry if it or any stage downstream of it holds a bubble, or the sink drains.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < LATENCY; k++) begin
            rdy[k] = bus.S_rdy;
            for (int j = k; j < LATENCY; j++) begin
                rdy[k] = rdy[k] | ~vld_q[j];
            end
        end
    end

    assign in_rdy    = rdy[0];
    assign fire      = bus.A_vld & bus.B_vld & in_rdy;
    assign bus.A_rdy = bus.B_vld & in_rdy;
    assign bus.B_rdy = bus.A_vld & in_rdy;

    always_comb begin
        res_d = '0;
        ovf_d = '0;
        for (int l = 0; l < LANES; l++) begin
            {ovf_d[l], res_d[l*WIDTH +: WIDTH]} =
                lane_op(bus.A_dat[l*WIDTH +: WIDTH], bus.B_dat[l*WIDTH +: WIDTH], bus.is_sub[l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                dat_q[k] <= '0;
                ovf_q[k] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                vld_q[0] <= fire;
                if (fire) begin
                    dat_q[0] <= res_d;
                    ovf_q[0] <= ovf_d;
                end
            end
            // Payload only moves with a valid entry so a stalled output stays put.
            for (int k = 1; k < LATENCY; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        dat_q[k] <= dat_q[k-1];
                        ovf_q[k] <= ovf_q[k-1];
                    end
                end
            end
        end
    end

    assign bus.S_vld = vld_q[LATENCY-1];
    assign bus.S_dat = dat_q[LATENCY-1];
    assign bus.S_ovf = ovf_q[LATENCY-1];
    assign bus.busy  = |vld_q;

endmodule

// File: tb/tb_sif_addsub_pipe.sv
// Bench for sif_addsub_pipe: lane vector table, stall/join/reset sequences, random stream.
// Expectations follow SIF_ADDSUB_SAT_EN the same way the design does.
module tb_sif_addsub_pipe;
  localparam int WIDTH   = 16;
  localparam int LANES   = 4;
  localparam int LATENCY = 2;
  localparam int EW      = LANES*WIDTH + LANES;
  localparam int MAXV    = 2**(WIDTH-1) - 1;
  localparam int MINV    = -(2**(WIDTH-1));

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] r_wrap;
    logic [WIDTH-1:0] r_sat;
    logic             ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   n_pop;
  logic [EW-1:0] exp_q[$];
  vec_t vecs[12];

  sif_addsub_pipe_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

  sif_addsub_pipe #(.WIDTH(WIDTH), .LANES(LANES), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic sub);
    int sa, sb, r;
    logic o;
    logic [WIDTH-1:0] v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    o  = (r > MAXV) || (r < MINV);
    v  = r[WIDTH-1:0];
`ifdef SIF_ADDSUB_SAT_EN
    if (o) v = (r > 0) ? WIDTH'(MAXV) : WIDTH'(MINV);
`endif
    return {o, v};
  endfunction

  // driver tasks
  task automatic idle();
    bus.A_vld = 1'b0;
    bus.B_vld = 1'b0;
  endtask

  task automatic send(input logic [LANES*WIDTH-1:0] a, input logic [LANES*WIDTH-1:0] b,
                      input logic [LANES-1:0] sub, input logic [EW-1:0] exp);
    int t;
    t = 0;
    bus.A_dat  = a;
    bus.B_dat  = b;
    bus.is_sub = sub;
    bus.A_vld  = 1'b1;
    bus.B_vld  = 1'b1;
    @(negedge clk);
    while (!(bus.A_rdy && bus.B_rdy) && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no ready in %0d cycles, expected ready", t);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_group(input int g);
    logic [LANES*WIDTH-1:0] a, b, r;
    logic [LANES-1:0] s, o;
    for (int l = 0; l < LANES; l++) begin
      a[l*WIDTH +: WIDTH] = vecs[g*LANES+l].a;
      b[l*WIDTH +: WIDTH] = vecs[g*LANES+l].b;
      s[l] = vecs[g*LANES+l].sub;
      o[l] = vecs[g*LANES+l].ovf;
`ifdef SIF_ADDSUB_SAT_EN
      r[l*WIDTH +: WIDTH] = vecs[g*LANES+l].r_sat;
`else
      r[l*WIDTH +: WIDTH] = vecs[g*LANES+l].r_wrap;
`endif
    end
    send(a, b, s, {o, r});
  endtask

  task automatic send_rand();
    logic [LANES*WIDTH-1:0] a, b, r;
    logic [LANES-1:0] s, o;
    for (int l = 0; l < LANES; l++) begin
      a[l*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 2**WIDTH - 1));
      b[l*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 2**WIDTH - 1));
      s[l] = 1'($urandom_range(0, 1));
      {o[l], r[l*WIDTH +: WIDTH]} = model(a[l*WIDTH +: WIDTH], b[l*WIDTH +: WIDTH], s[l]);
    end
    send(a, b, s, {o, r});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic measure_latency(input string name);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!bus.S_vld && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check(name, 128'(lat), 128'(LATENCY));
  endtask

  // scoreboard: every valid output cycle is compared to the queue head, popped on transfer
  always @(negedge clk) begin
    if (rst_n && bus.S_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %h, expected no output", {bus.S_ovf, bus.S_dat});
      end else begin
        check("s_result", 128'({bus.S_ovf, bus.S_dat}), 128'(exp_q[0]));
        if (bus.S_rdy) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  initial begin
    int p0;
    logic done;
    n_cmp = 0;
    n_err = 0;
    n_pop = 0;
    done  = 1'b0;
    vecs = '{
      '{16'h0005, 16'h0003, 1'b1, 16'h0002, 16'h0002, 1'b0},
      '{16'h0005, 16'h0003, 1'b0, 16'h0008, 16'h0008, 1'b0},
      '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1},
      '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b1},
      '{16'h0000, 16'h8000, 1'b1, 16'h8000, 16'h7FFF, 1'b1},
      '{16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 16'h7FFF, 1'b0},
      '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1},
      '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0},
      '{16'h1234, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b0},
      '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 16'h7FFF, 1'b1},
      '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 16'h8000, 1'b1},
      '{16'h0100, 16'h0200, 1'b0, 16'h0300, 16'h0300, 1'b0}
    };
    bus.is_sub = '0;
    bus.A_dat  = '0;
    bus.B_dat  = '0;
    bus.S_rdy  = 1'b1;
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_vld", 128'(bus.S_vld), 128'(0));
    check("rst_busy",  128'(bus.busy),  128'(0));
    check("rst_s_dat", 128'(bus.S_dat), 128'(0));
    check("rst_s_ovf", 128'(bus.S_ovf), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table vectors: group 0 has is_sub = 4'b0101, latency checked on the lone beat
    send_group(0);
    idle();
    measure_latency("latency_first");
    drain();
    for (int g = 1; g < 3; g++) send_group(g);
    idle();
    drain();
    check("busy_idle", 128'(bus.busy), 128'(0));

    // 8-beat stream with sink stalled for cycles 3..6
    p0 = n_pop;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        idle();
      end
      begin
        for (int c = 0; c < 9; c++) begin
          bus.S_rdy = !(c >= 3 && c <= 6);
          @(negedge clk);
          if (c == 5) begin
            check("stall_a_rdy", 128'(bus.A_rdy), 128'(0));
            check("stall_b_rdy", 128'(bus.B_rdy), 128'(0));
            check("stall_busy",  128'(bus.busy),  128'(1));
          end
          @(posedge clk);
          #1;
        end
        bus.S_rdy = 1'b1;
      end
    join
    drain();
    check("stream_count", 128'(n_pop - p0), 128'(8));

    // A alone must not fire
    p0 = n_pop;
    bus.A_vld = 1'b1;
    bus.B_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("join_a_rdy", 128'(bus.A_rdy), 128'(0));
      check("join_b_rdy", 128'(bus.B_rdy), 128'(1));
      check("join_busy",  128'(bus.busy),  128'(0));
      @(posedge clk);
      #1;
    end
    send_group(2);
    idle();
    drain();
    check("join_count", 128'(n_pop - p0), 128'(1));

    // reset with two entries in flight
    send_group(0);
    send_group(1);
    idle();
    rst_n = 1'b0;
    #1;
    check("midrst_s_vld", 128'(bus.S_vld), 128'(0));
    check("midrst_busy",  128'(bus.busy),  128'(0));
    check("midrst_s_dat", 128'(bus.S_dat), 128'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", 128'(bus.S_vld), 128'(0));
    end
    @(posedge clk);
    #1;
    send_group(2);
    idle();
    measure_latency("latency_after_rst");
    drain();

    // random stream with random gaps and backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
          send_rand();
        end
        idle();
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.S_rdy = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        bus.S_rdy = 1'b1;
      end
    join
    drain();
    check("final_busy", 128'(bus.busy), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected finish");
    $fatal(1, "timeout");
  end
endmodule
